core_ibex_xif_instr_trace_buf: RTL and testbench
================================================

# core_ibex_xif_instr_trace_buf

Parametrised ID-stage instruction trace buffer for the core_ibex DV environment. Watches the ID-stage probe signals and assembles one record per instruction that leaves ID. Each record carries the PC, encoding, order tag, stall count and control-flow outcome. Records queue in a DEPTH-entry FIFO that a monitor drains through a valid/ready port. Overflow is counted instead of back-pressuring the core.

## Interface
- DATA_WIDTH, 32: width of PC, instruction and branch target.
- DEPTH, 8: FIFO entries; power of two, >= 2.
- STALL_W, 8: width of the per-instruction stall counter.
- OVF_W, 16: width of the overflow counter.
- clk_i  in  1  clock; one clock, all logic on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_id_i  in  1  ID stage holds a valid instruction.
- instr_new_id_i  in  1  first cycle of a new instruction in ID.
- err_id_i  in  1  fetch error on the instruction.
- is_compressed_id_i  in  1  instruction was compressed.
- instr_compressed_id_i  in  16  original compressed encoding.
- instr_id_i  in  DATA_WIDTH  decompressed instruction.
- pc_id_i  in  DATA_WIDTH  instruction PC.
- branch_taken_id_i  in  1  branch taken this cycle.
- jump_set_id_i  in  1  jump target set this cycle.
- branch_target_id_i  in  DATA_WIDTH  control-flow target.
- stall_id_i  in  1  ID stalled this cycle.
- rvfi_order_id_i  in  64  RVFI order tag.
- rec_valid_o  out  1  head record available.
- rec_ready_i  in  1  consumer accepts the head record.
- rec_pc_o, rec_instr_o, rec_target_o  out  DATA_WIDTH  head record fields.
- rec_instr_c_o  out  16; rec_order_o  out  64; rec_stall_o  out  STALL_W.
- rec_err_o, rec_compressed_o, rec_branch_o, rec_jump_o  out  1 each.
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf_cnt_o  out  OVF_W  dropped records, saturating.
- ovf_o  out  1  sticky: at least one drop since reset.

## Operation
- Open-record register (open flag plus fields). Its state is OPEN or IDLE.
- Start: valid_id_i && instr_new_id_i.
  - Loads pc, instr, instr_c, compressed, err and order from the inputs.
  - Clears stall count, branch flag and jump flag.
  - If a record was already OPEN, the new one replaces it. The old record is discarded and is not counted as overflow.
- While OPEN or starting, any cycle with valid_id_i && stall_id_i adds 1 to the stall count. The count saturates at 2^STALL_W-1.
- Any cycle with branch_taken_id_i or jump_set_id_i (while OPEN or starting):
  - Sets the matching flag.
  - Latches branch_target_id_i. If several such cycles occur, the last target wins.
- Close: valid_id_i && !stall_id_i while OPEN or starting.
  - Pushes the record, including any flag or target events from the closing cycle. Fields captured in the start cycle come from the live inputs.
  - State becomes IDLE.
- A start cycle with stall_id_i=0 is both start and close, giving a single-cycle record with stall count 0.
- Kill: valid_id_i=0 while OPEN. The record is discarded with no push and the state becomes IDLE.
- Push into a full FIFO with no pop in the same cycle:
  - The record is dropped.
  - ovf_cnt_o increments (saturating at all-ones) and ovf_o sets.
- Push and pop in the same cycle while full: the push is accepted and the level is unchanged.
- Pop: rec_valid_o && rec_ready_i. rec_ready_i has no effect while the FIFO is empty.
- Pointers wrap modulo DEPTH. Occupancy is tracked with an extra pointer bit. level_o ranges over 0..DEPTH.

## Timing
- Record pushed at edge N: rec_valid_o=1 after edge N when previously empty. Latency is 1 cycle from the closing cycle.
- Head fields are stable while rec_valid_o=1 && rec_ready_i=0. No combinational path from rec_ready_i to rec_valid_o.
- Throughput is 1 push and 1 pop per cycle.
- Reset asserted, at any time and asynchronously:
  - rec_valid_o=0, level_o=0, ovf_cnt_o=0, ovf_o=0.
  - All rec_* data outputs read 0.
  - State is IDLE and the FIFO is emptied. Any open or queued records are lost.
- First capture is possible in the first rising edge after rst_ni deasserts.

## Test plan
- Single-cycle instruction: start+close with pc=0x80, instr=0x00500093, order=5, ready=1 -> one record next cycle with pc=0x80, stall=0, branch=0, and level returns to 0.
- Stalled branch: start at pc=0x100, 3 stall cycles, branch_taken with target=0x200 on the last stall cycle, then close -> stall=3, branch=1, target=0x200.
- Compressed fetch error: start with is_compressed=1, instr_c=0x4505, err=1 -> rec_compressed_o=1, rec_instr_c_o=0x4505, rec_err_o=1.
- Overflow, DEPTH=8: ready=0, 10 single-cycle instructions -> level_o=8, ovf_cnt_o=2, ovf_o=1. Draining yields the first 8 orders in sequence.
- Full with simultaneous push+pop: level stays 8, ovf_cnt_o unchanged, output order preserved across pointer wrap.
- Kill and reset: start then valid_id_i=0 -> no record. Assert rst_ni=0 with 4 entries queued -> rec_valid_o and level_o go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/core_ibex_xif_instr_trace_buf.sv
// ID-stage instruction trace buffer: assembles one record per instruction leaving ID
// and queues it in a DEPTH-entry FIFO drained over a valid/ready port; drops are counted.
module core_ibex_xif_instr_trace_buf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned STALL_W    = 8,
  parameter int unsigned OVF_W      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_id_i,
  input  logic                     instr_new_id_i,
  input  logic                     err_id_i,
  input  logic                     is_compressed_id_i,
  input  logic [15:0]              instr_compressed_id_i,
  input  logic [DATA_WIDTH-1:0]    instr_id_i,
  input  logic [DATA_WIDTH-1:0]    pc_id_i,
  input  logic                     branch_taken_id_i,
  input  logic                     jump_set_id_i,
  input  logic [DATA_WIDTH-1:0]    branch_target_id_i,
  input  logic                     stall_id_i,
  input  logic [63:0]              rvfi_order_id_i,
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [DATA_WIDTH-1:0]    rec_pc_o,
  output logic [DATA_WIDTH-1:0]    rec_instr_o,
  output logic [DATA_WIDTH-1:0]    rec_target_o,
  output logic [15:0]              rec_instr_c_o,
  output logic [63:0]              rec_order_o,
  output logic [STALL_W-1:0]       rec_stall_o,
  output logic                     rec_err_o,
  output logic                     rec_compressed_o,
  output logic                     rec_branch_o,
  output logic                     rec_jump_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [OVF_W-1:0]         ovf_cnt_o,
  output logic                     ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] target;
    logic [15:0]           instr_c;
    logic [63:0]           order;
    logic [STALL_W-1:0]    stall;
    logic                  err;
    logic                  compressed;
    logic                  branch;
    logic                  jump;
  } rec_t;

  typedef enum logic {ST_IDLE, ST_OPEN} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  rec_t        r_open;
  rec_t        w_rec;
  logic        w_start;
  logic        w_active;
  logic        w_close;

  rec_t        r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [AW:0] w_level;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  rec_t        w_head;
  logic [OVF_W-1:0] r_ovf_cnt;
  logic        r_ovf;

  assign w_start  = valid_id_i && instr_new_id_i;
  assign w_active = w_start || (r_state == ST_OPEN);
  assign w_close  = w_active && valid_id_i && !stall_id_i;

  // Record under assembly: start fields come from live inputs, events of this cycle folded in.
  always_comb begin
    w_state_nxt = r_state;
    w_rec       = r_open;
    if (w_start) begin
      w_rec.pc         = pc_id_i;
      w_rec.instr      = instr_id_i;
      w_rec.instr_c    = instr_compressed_id_i;
      w_rec.compressed = is_compressed_id_i;
      w_rec.err        = err_id_i;
      w_rec.order      = rvfi_order_id_i;
      w_rec.stall      = '0;
      w_rec.branch     = 1'b0;
      w_rec.jump       = 1'b0;
      w_rec.target     = '0;
    end
    if (w_active && valid_id_i && stall_id_i && (w_rec.stall != '1)) begin
      w_rec.stall = w_rec.stall + STALL_W'(1);
    end
    if (w_active && branch_taken_id_i) begin
      w_rec.branch = 1'b1;
      w_rec.target = branch_target_id_i;
    end
    if (w_active && jump_set_id_i) begin
      w_rec.jump   = 1'b1;
      w_rec.target = branch_target_id_i;
    end
    if (w_close || !valid_id_i) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = ST_OPEN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_open  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_open  <= w_rec;
    end
  end

  assign w_level = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_level == FULL_LVL);
  assign w_pop   = !w_empty && rec_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push  = w_close && (!w_full || w_pop);
  assign w_drop  = w_close && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_rec;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ovf_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
      end
    end
  end

  // Data outputs read zero whenever nothing is queued, including straight out of reset.
  assign w_head           = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign rec_valid_o      = !w_empty;
  assign rec_pc_o         = w_head.pc;
  assign rec_instr_o      = w_head.instr;
  assign rec_target_o     = w_head.target;
  assign rec_instr_c_o    = w_head.instr_c;
  assign rec_order_o      = w_head.order;
  assign rec_stall_o      = w_head.stall;
  assign rec_err_o        = w_head.err;
  assign rec_compressed_o = w_head.compressed;
  assign rec_branch_o     = w_head.branch;
  assign rec_jump_o       = w_head.jump;
  assign level_o          = w_level;
  assign ovf_cnt_o        = r_ovf_cnt;
  assign ovf_o            = r_ovf;

endmodule

// File: tb/tb_core_ibex_xif_instr_trace_buf.sv
// Bench for the ID-stage trace buffer: directed scenarios plus random traffic
// checked against a queue-based model of records, drops and occupancy.
module tb_core_ibex_xif_instr_trace_buf;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_id = 1'b0, instr_new_id = 1'b0, err_id = 1'b0, comp_id = 1'b0;
  logic [15:0] ic_id = '0;
  logic [31:0] instr_id = '0, pc_id = '0, tgt_id = '0;
  logic        br_id = 1'b0, jp_id = 1'b0, stall_id = 1'b0;
  logic [63:0] order_id = '0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [31:0] rec_pc, rec_instr, rec_target;
  logic [15:0] rec_instr_c;
  logic [63:0] rec_order;
  logic [7:0]  rec_stall;
  logic        rec_err, rec_comp, rec_branch, rec_jump;
  logic [3:0]  level;
  logic [15:0] ovf_cnt;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc, instr, tgt;
    logic [15:0] ic;
    logic [63:0] order;
    int          stall;
    bit          err, comp, br, jp;
  } mrec_t;

  mrec_t mq[$];
  mrec_t m_cur;
  bit    m_open = 0;
  bit    m_ovf = 0;
  int    m_ovf_cnt = 0;

  core_ibex_xif_instr_trace_buf dut (
    .clk_i(clk), .rst_ni(rst_n),
    .valid_id_i(valid_id), .instr_new_id_i(instr_new_id), .err_id_i(err_id),
    .is_compressed_id_i(comp_id), .instr_compressed_id_i(ic_id), .instr_id_i(instr_id),
    .pc_id_i(pc_id), .branch_taken_id_i(br_id), .jump_set_id_i(jp_id),
    .branch_target_id_i(tgt_id), .stall_id_i(stall_id), .rvfi_order_id_i(order_id),
    .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
    .rec_pc_o(rec_pc), .rec_instr_o(rec_instr), .rec_target_o(rec_target),
    .rec_instr_c_o(rec_instr_c), .rec_order_o(rec_order), .rec_stall_o(rec_stall),
    .rec_err_o(rec_err), .rec_compressed_o(rec_comp), .rec_branch_o(rec_branch),
    .rec_jump_o(rec_jump), .level_o(level), .ovf_cnt_o(ovf_cnt), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  // Advance the model by one cycle using the inputs currently driven, then clock the DUT.
  task automatic cycle();
    bit    pop;
    bit    push;
    mrec_t r;
    pop  = (mq.size() != 0) && rec_ready;
    push = 0;
    if (valid_id && instr_new_id) begin
      m_open = 1;
      m_cur = '{pc:pc_id, instr:instr_id, tgt:32'h0, ic:ic_id, order:order_id,
                stall:0, err:err_id, comp:comp_id, br:0, jp:0};
    end
    if (m_open) begin
      if (valid_id && stall_id && m_cur.stall < 255) m_cur.stall++;
      if (br_id) begin m_cur.br = 1; m_cur.tgt = tgt_id; end
      if (jp_id) begin m_cur.jp = 1; m_cur.tgt = tgt_id; end
      if (valid_id && !stall_id) begin push = 1; r = m_cur; m_open = 0; end
      else if (!valid_id) m_open = 0;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else begin m_ovf = 1; if (m_ovf_cnt < 65535) m_ovf_cnt++; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    valid_id = 0; instr_new_id = 0; stall_id = 0; br_id = 0; jp_id = 0;
    err_id = 0; comp_id = 0; ic_id = '0;
  endtask

  task automatic drive_single(input logic [31:0] pc, input logic [63:0] order);
    drive_idle();
    valid_id = 1; instr_new_id = 1; pc_id = pc; order_id = order; instr_id = 32'h00500093;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (rec_valid !== 1'b0 || level !== 4'd0) begin
      n_fail++; $display("FAIL reset_hold: valid=%0b level=%0d want 0/0", rec_valid, level);
    end
    rst_n = 1;
    cycle();
    n_tests++;
    if (rec_valid !== 1'b0 || level !== 4'd0 || ovf_cnt !== 16'd0 || ovf !== 1'b0 || rec_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b level=%0d ovf_cnt=%0d ovf=%0b pc=%h want all 0",
               rec_valid, level, ovf_cnt, ovf, rec_pc);
    end
  endtask

  task automatic test_single();
    rec_ready = 1;
    drive_single(32'h80, 64'd5);
    cycle();
    drive_idle();
    n_tests++;
    if (rec_valid !== 1'b1 || rec_pc !== 32'h80 || rec_instr !== 32'h00500093 || rec_order !== 64'd5 ||
        rec_stall !== 8'd0 || rec_branch !== 1'b0 || level !== 4'd1) begin
      n_fail++;
      $display("FAIL single_rec: valid=%0b pc=%h instr=%h order=%0d stall=%0d br=%0b level=%0d want 1/80/00500093/5/0/0/1",
               rec_valid, rec_pc, rec_instr, rec_order, rec_stall, rec_branch, level);
    end
    cycle();
    n_tests++;
    if (rec_valid !== 1'b0 || level !== 4'd0) begin
      n_fail++; $display("FAIL single_drain: valid=%0b level=%0d want 0/0", rec_valid, level);
    end
  endtask

  task automatic test_stalled_branch();
    rec_ready = 0;
    drive_single(32'h100, 64'd10);
    stall_id = 1;
    cycle();
    instr_new_id = 0;
    cycle();
    br_id = 1; tgt_id = 32'h200;
    cycle();
    br_id = 0; stall_id = 0; tgt_id = 32'hdead_beef;
    cycle();
    drive_idle();
    n_tests++;
    if (rec_valid !== 1'b1 || rec_pc !== 32'h100 || rec_stall !== 8'd3 || rec_branch !== 1'b1 ||
        rec_jump !== 1'b0 || rec_target !== 32'h200) begin
      n_fail++;
      $display("FAIL stalled_branch: valid=%0b pc=%h stall=%0d br=%0b jp=%0b tgt=%h want 1/100/3/1/0/200",
               rec_valid, rec_pc, rec_stall, rec_branch, rec_jump, rec_target);
    end
    rec_ready = 1;
    cycle();
  endtask

  task automatic test_compressed_err();
    rec_ready = 0;
    drive_single(32'h300, 64'd11);
    comp_id = 1; ic_id = 16'h4505; err_id = 1;
    cycle();
    drive_idle();
    n_tests++;
    if (rec_valid !== 1'b1 || rec_comp !== 1'b1 || rec_instr_c !== 16'h4505 || rec_err !== 1'b1) begin
      n_fail++;
      $display("FAIL compressed_err: valid=%0b comp=%0b ic=%h err=%0b want 1/1/4505/1",
               rec_valid, rec_comp, rec_instr_c, rec_err);
    end
    rec_ready = 1;
    cycle();
  endtask

  task automatic test_overflow();
    rec_ready = 0;
    for (int i = 0; i < 10; i++) begin
      drive_single(32'h1000 + 32'(4 * i), 64'(100 + i));
      cycle();
    end
    drive_idle();
    n_tests++;
    if (level !== 4'd8 || ovf_cnt !== 16'd2 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL overflow: level=%0d ovf_cnt=%0d ovf=%0b want 8/2/1", level, ovf_cnt, ovf);
    end
    rec_ready = 1;
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (rec_valid !== 1'b1 || rec_order !== 64'(100 + k)) begin
        n_fail++; $display("FAIL overflow_drain: valid=%0b order=%0d want 1/%0d", rec_valid, rec_order, 100 + k);
      end
      cycle();
    end
    n_tests++;
    if (level !== 4'd0) begin
      n_fail++; $display("FAIL overflow_empty: level=%0d want 0", level);
    end
  endtask

  task automatic test_full_push_pop();
    rec_ready = 0;
    for (int i = 0; i < 8; i++) begin
      drive_single(32'h2000, 64'(200 + i));
      cycle();
    end
    rec_ready = 1;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (rec_order !== 64'(200 + i)) begin
        n_fail++; $display("FAIL full_head: order=%0d want %0d", rec_order, 200 + i);
      end
      drive_single(32'h2000, 64'(208 + i));
      cycle();
      n_tests++;
      if (level !== 4'd8 || ovf_cnt !== 16'd2) begin
        n_fail++; $display("FAIL full_level: level=%0d ovf_cnt=%0d want 8/2", level, ovf_cnt);
      end
    end
    drive_idle();
    for (int k = 6; k < 14; k++) begin
      n_tests++;
      if (rec_valid !== 1'b1 || rec_order !== 64'(200 + k)) begin
        n_fail++; $display("FAIL full_wrap: valid=%0b order=%0d want 1/%0d", rec_valid, rec_order, 200 + k);
      end
      cycle();
    end
    n_tests++;
    if (level !== 4'd0 || rec_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_empty: level=%0d valid=%0b want 0/0", level, rec_valid);
    end
  endtask

  task automatic test_kill();
    rec_ready = 1;
    drive_single(32'h400, 64'd20);
    stall_id = 1;
    cycle();
    drive_idle();
    cycle();
    br_id = 1; tgt_id = 32'h500;
    cycle();
    br_id = 0;
    valid_id = 1;
    cycle();
    drive_idle();
    cycle();
    n_tests++;
    if (rec_valid !== 1'b0 || level !== 4'd0) begin
      n_fail++; $display("FAIL kill: valid=%0b level=%0d want 0/0", rec_valid, level);
    end
  endtask

  task automatic test_stall_sat();
    rec_ready = 0;
    drive_single(32'h600, 64'd30);
    stall_id = 1;
    cycle();
    instr_new_id = 0;
    repeat (299) cycle();
    stall_id = 0; jp_id = 1; tgt_id = 32'h700;
    cycle();
    drive_idle();
    n_tests++;
    if (rec_valid !== 1'b1 || rec_stall !== 8'hff || rec_jump !== 1'b1 || rec_target !== 32'h700) begin
      n_fail++;
      $display("FAIL stall_sat: valid=%0b stall=%0d jp=%0b tgt=%h want 1/255/1/700",
               rec_valid, rec_stall, rec_jump, rec_target);
    end
    rec_ready = 1;
    cycle();
  endtask

  task automatic test_random();
    logic [63:0] ord;
    int          ready_pct;
    ord = 64'd1000;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) ready_pct = (c % 1000 == 0) ? 80 : 20;
      valid_id     = ($urandom_range(0, 9) != 0);
      instr_new_id = ($urandom_range(0, 2) == 0);
      stall_id     = ($urandom_range(0, 2) == 0);
      br_id        = ($urandom_range(0, 7) == 0);
      jp_id        = ($urandom_range(0, 7) == 0);
      err_id       = ($urandom_range(0, 7) == 0);
      comp_id      = $urandom_range(0, 1) != 0;
      ic_id        = 16'($urandom);
      instr_id     = $urandom;
      pc_id        = $urandom;
      tgt_id       = $urandom;
      order_id     = ord;
      ord++;
      rec_ready    = ($urandom_range(0, 99) < ready_pct);
      cycle();
      n_tests++;
      if (rec_valid !== (mq.size() != 0) || level !== 4'(mq.size()) ||
          ovf_cnt !== 16'(m_ovf_cnt) || ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_state c=%0d: valid=%0b level=%0d ovf_cnt=%0d ovf=%0b want %0b/%0d/%0d/%0b",
                 c, rec_valid, level, ovf_cnt, ovf, mq.size() != 0, mq.size(), m_ovf_cnt, m_ovf);
      end
      if (mq.size() != 0) begin
        n_tests++;
        if (rec_order !== mq[0].order || rec_pc !== mq[0].pc || rec_instr !== mq[0].instr ||
            rec_instr_c !== mq[0].ic || rec_stall !== 8'(mq[0].stall) || rec_err !== mq[0].err ||
            rec_comp !== mq[0].comp || rec_branch !== mq[0].br || rec_jump !== mq[0].jp ||
            ((mq[0].br || mq[0].jp) && rec_target !== mq[0].tgt)) begin
          n_fail++;
          $display("FAIL rand_head c=%0d: order=%0d pc=%h stall=%0d br=%0b jp=%0b tgt=%h want %0d/%h/%0d/%0b/%0b/%h",
                   c, rec_order, rec_pc, rec_stall, rec_branch, rec_jump, rec_target,
                   mq[0].order, mq[0].pc, mq[0].stall, mq[0].br, mq[0].jp, mq[0].tgt);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive_idle();
    rec_ready = 1;
    repeat (10) cycle();
    rec_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive_single(32'h3000, 64'(500 + i));
      cycle();
    end
    drive_idle();
    n_tests++;
    if (level !== 4'd4 || rec_valid !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre: level=%0d valid=%0b want 4/1", level, rec_valid);
    end
    #2;
    rst_n = 0;
    #1;
    n_tests++;
    if (rec_valid !== 1'b0 || level !== 4'd0 || ovf !== 1'b0 || ovf_cnt !== 16'd0 ||
        rec_order !== 64'd0 || rec_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL areset_now: valid=%0b level=%0d ovf=%0b ovf_cnt=%0d order=%0d pc=%h want all 0",
               rec_valid, level, ovf, ovf_cnt, rec_order, rec_pc);
    end
    mq.delete();
    m_open = 0; m_ovf = 0; m_ovf_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    rec_ready = 1;
    drive_single(32'h4000, 64'd900);
    cycle();
    drive_idle();
    n_tests++;
    if (rec_valid !== 1'b1 || rec_order !== 64'd900 || level !== 4'd1) begin
      n_fail++; $display("FAIL areset_after: valid=%0b order=%0d level=%0d want 1/900/1", rec_valid, rec_order, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stalled_branch();
    test_compressed_err();
    test_overflow();
    test_full_push_pop();
    test_kill();
    test_stall_sat();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
